// File: rtl/fuel_ctrl_pkg.sv
// Shared definitions for the fuel controller: FSM state encoding seen on the state output.
package fuel_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_EMPTY  = 2'b11
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Mod-DIV_MAX counter producing the burn tick; holds its count while disabled.
module tick_prescaler #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic syn_clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_MAX - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (syn_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fuel_ctrl.sv
// Fuel reserve sequencer: full tank on start, per-tick burn, pickup/crash adjust,
// saturating arithmetic and exhaustion flag for the game FSM.
module fuel_ctrl
  import fuel_ctrl_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned FUEL_MAX = 255,
  parameter int unsigned REFILL   = 32,
  parameter int unsigned PENALTY  = 16,
  parameter int unsigned LOW_TH   = 32,
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned DIV_MAX  = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               pickup,
  input  logic               crash,
  output logic [N-1:0]       fuel,
  output logic               low,
  output logic               empty_tick,
  output logic [STATE_W-1:0] state
);

  // Two guard bits keep fuel + REFILL and fuel - PENALTY - 1 representable before clamping.
  localparam int unsigned SW = N + 2;

  localparam logic [N-1:0]         FUEL_MAX_N = N'(FUEL_MAX);
  localparam logic [N-1:0]         LOW_TH_N   = N'(LOW_TH);
  localparam logic signed [SW-1:0] REFILL_S   = SW'(REFILL);
  localparam logic signed [SW-1:0] PENALTY_S  = SW'(PENALTY);
  localparam logic signed [SW-1:0] MAX_S      = SW'(FUEL_MAX);
  localparam logic signed [SW-1:0] ONE_S      = SW'(1);
  localparam logic signed [SW-1:0] ZERO_S     = '0;

  state_e               state_q, state_d;
  logic [N-1:0]         fuel_q, fuel_d;
  logic                 empty_tick_q, empty_tick_d;
  logic                 tick;
  logic                 pre_en_c;
  logic signed [SW-1:0] sum_c;
  logic [N-1:0]         clamp_c;

  // Prescaler only advances in RUN when no higher-priority start/pause is present.
  assign pre_en_c = (state_q == ST_RUN) && !pause && !start;

  tick_prescaler #(
    .DIV_W  (DIV_W),
    .DIV_MAX(DIV_MAX)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (pre_en_c),
    .syn_clr(start),
    .tick   (tick)
  );

  always_comb begin
    sum_c = $signed({2'b00, fuel_q})
          + (pickup ? REFILL_S  : ZERO_S)
          - (crash  ? PENALTY_S : ZERO_S)
          - (tick   ? ONE_S     : ZERO_S);
    if (sum_c < ZERO_S) begin
      clamp_c = '0;
    end else if (sum_c > MAX_S) begin
      clamp_c = FUEL_MAX_N;
    end else begin
      clamp_c = sum_c[N-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    fuel_d       = fuel_q;
    empty_tick_d = 1'b0;
    if (start) begin
      state_d = ST_RUN;
      fuel_d  = FUEL_MAX_N;
    end else begin
      unique case (state_q)
        ST_IDLE: fuel_d = '0;
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            fuel_d = clamp_c;
            if (clamp_c == '0) begin
              state_d      = ST_EMPTY;
              empty_tick_d = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_EMPTY: fuel_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fuel_q       <= '0;
      empty_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fuel_q       <= fuel_d;
      empty_tick_q <= empty_tick_d;
    end
  end

  assign low        = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && (fuel_q < LOW_TH_N);
  assign fuel       = fuel_q;
  assign empty_tick = empty_tick_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fuel_ctrl.sv
// Directed bench for fuel_ctrl with a small tank (10) and a 4-clock burn tick.
module tb_fuel_ctrl;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         pause;
  logic         pickup;
  logic         crash;
  logic [N-1:0] fuel;
  logic         low;
  logic         empty_tick;
  logic [1:0]   state;

  int checks;
  int errors;

  fuel_ctrl #(
    .N       (N),
    .FUEL_MAX(10),
    .REFILL  (5),
    .PENALTY (4),
    .LOW_TH  (3),
    .DIV_W   (4),
    .DIV_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .pickup    (pickup),
    .crash     (crash),
    .fuel      (fuel),
    .low       (low),
    .empty_tick(empty_tick),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pause = 1'b0; pickup = 1'b0; crash = 1'b0;
    step(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (fuel !== 8'd0) begin errors++; $display("FAIL reset_fuel got %0d exp 0", fuel); end
    checks++; if (low !== 1'b0 || empty_tick !== 1'b0) begin errors++; $display("FAIL reset_flags low=%b et=%b exp 0 0", low, empty_tick); end
    reset = 1'b1;
    pickup = 1'b1; pause = 1'b1;
    step(1);
    pickup = 1'b0; pause = 1'b0;
    checks++; if (state !== 2'd0 || fuel !== 8'd0) begin errors++; $display("FAIL idle_ignore state=%0d fuel=%0d exp 0 0", state, fuel); end
  endtask

  task automatic test_burn();
    logic [N-1:0] exp_f;
    logic [1:0]   exp_s;
    logic         exp_low;
    logic         exp_et;
    pulse_start();
    checks++; if (fuel !== 8'd10 || state !== 2'd1) begin errors++; $display("FAIL start_load fuel=%0d state=%0d exp 10 1", fuel, state); end
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_f   = N'(10 - k / 4);
      exp_s   = (k == 40) ? 2'd3 : 2'd1;
      exp_low = (exp_s == 2'd1) && (exp_f < 8'd3);
      exp_et  = (k == 40);
      checks++; if (fuel !== exp_f) begin errors++; $display("FAIL burn_fuel k=%0d got %0d exp %0d", k, fuel, exp_f); end
      checks++; if (state !== exp_s) begin errors++; $display("FAIL burn_state k=%0d got %0d exp %0d", k, state, exp_s); end
      checks++; if (low !== exp_low) begin errors++; $display("FAIL burn_low k=%0d got %b exp %b", k, low, exp_low); end
      checks++; if (empty_tick !== exp_et) begin errors++; $display("FAIL burn_empty_tick k=%0d got %b exp %b", k, empty_tick, exp_et); end
    end
    pickup = 1'b1; pause = 1'b1;
    step(1);
    pickup = 1'b0; pause = 1'b0;
    checks++; if (empty_tick !== 1'b0 || state !== 2'd3 || fuel !== 8'd0) begin errors++; $display("FAIL empty_hold et=%b state=%0d fuel=%0d exp 0 3 0", empty_tick, state, fuel); end
  endtask

  task automatic test_pickup();
    pulse_start();
    step(8);
    checks++; if (fuel !== 8'd8) begin errors++; $display("FAIL pickup_pre got %0d exp 8", fuel); end
    pickup = 1'b1; step(1); pickup = 1'b0;
    checks++; if (fuel !== 8'd10) begin errors++; $display("FAIL pickup_saturate got %0d exp 10", fuel); end
    step(27);
    checks++; if (fuel !== 8'd3 || low !== 1'b0) begin errors++; $display("FAIL pickup_at3_pre fuel=%0d low=%b exp 3 0", fuel, low); end
    pickup = 1'b1; step(1); pickup = 1'b0;
    checks++; if (fuel !== 8'd8) begin errors++; $display("FAIL pickup_add got %0d exp 8", fuel); end
  endtask

  task automatic test_crash();
    pulse_start();
    step(32);
    checks++; if (fuel !== 8'd2 || low !== 1'b1) begin errors++; $display("FAIL crash_pre fuel=%0d low=%b exp 2 1", fuel, low); end
    crash = 1'b1; step(1); crash = 1'b0;
    checks++; if (fuel !== 8'd0 || state !== 2'd3) begin errors++; $display("FAIL crash_empty fuel=%0d state=%0d exp 0 3", fuel, state); end
    checks++; if (empty_tick !== 1'b1 || low !== 1'b0) begin errors++; $display("FAIL crash_flags et=%b low=%b exp 1 0", empty_tick, low); end
    pickup = 1'b1; step(1); pickup = 1'b0;
    checks++; if (fuel !== 8'd0 || state !== 2'd3 || empty_tick !== 1'b0) begin errors++; $display("FAIL crash_pickup_ignored fuel=%0d state=%0d et=%b exp 0 3 0", fuel, state, empty_tick); end
  endtask

  task automatic test_pause();
    pulse_start();
    step(2);
    pause = 1'b1;
    step(10);
    pickup = 1'b1; step(1); pickup = 1'b0;
    step(9);
    checks++; if (fuel !== 8'd10 || state !== 2'd2) begin errors++; $display("FAIL pause_frozen fuel=%0d state=%0d exp 10 2", fuel, state); end
    pause = 1'b0;
    step(1);
    checks++; if (fuel !== 8'd10 || state !== 2'd1) begin errors++; $display("FAIL pause_release fuel=%0d state=%0d exp 10 1", fuel, state); end
    step(1);
    checks++; if (fuel !== 8'd10) begin errors++; $display("FAIL pause_phase_early got %0d exp 10", fuel); end
    step(1);
    checks++; if (fuel !== 8'd9) begin errors++; $display("FAIL pause_phase_tick got %0d exp 9", fuel); end
  endtask

  task automatic test_coincide();
    pulse_start();
    step(3);
    pickup = 1'b1; step(1); pickup = 1'b0;
    checks++; if (fuel !== 8'd10) begin errors++; $display("FAIL coincide_sat_tick got %0d exp 10", fuel); end
    step(23);
    checks++; if (fuel !== 8'd5) begin errors++; $display("FAIL coincide_pre5 got %0d exp 5", fuel); end
    pickup = 1'b1; crash = 1'b1; step(1); pickup = 1'b0; crash = 1'b0;
    checks++; if (fuel !== 8'd5 || state !== 2'd1) begin errors++; $display("FAIL coincide_all3 fuel=%0d state=%0d exp 5 1", fuel, state); end
    step(19);
    checks++; if (fuel !== 8'd1 || low !== 1'b1) begin errors++; $display("FAIL coincide_pre1 fuel=%0d low=%b exp 1 1", fuel, low); end
    crash = 1'b1; step(1); crash = 1'b0;
    checks++; if (fuel !== 8'd0 || state !== 2'd3 || empty_tick !== 1'b1) begin errors++; $display("FAIL coincide_empty fuel=%0d state=%0d et=%b exp 0 3 1", fuel, state, empty_tick); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++; if (fuel !== 8'd10 || state !== 2'd1) begin errors++; $display("FAIL restart_from_empty fuel=%0d state=%0d exp 10 1", fuel, state); end
    step(5);
    checks++; if (fuel !== 8'd9) begin errors++; $display("FAIL restart_burn got %0d exp 9", fuel); end
    pulse_start();
    checks++; if (fuel !== 8'd10 || state !== 2'd1) begin errors++; $display("FAIL restart_in_run fuel=%0d state=%0d exp 10 1", fuel, state); end
    step(3);
    #2 reset = 1'b0;
    #1;
    checks++; if (fuel !== 8'd0 || state !== 2'd0) begin errors++; $display("FAIL async_reset fuel=%0d state=%0d exp 0 0", fuel, state); end
    checks++; if (low !== 1'b0 || empty_tick !== 1'b0) begin errors++; $display("FAIL async_reset_flags low=%b et=%b exp 0 0", low, empty_tick); end
    step(1);
    reset = 1'b1;
    step(2);
    checks++; if (fuel !== 8'd0 || state !== 2'd0) begin errors++; $display("FAIL post_reset_idle fuel=%0d state=%0d exp 0 0", fuel, state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_burn();
    test_pickup();
    test_crash();
    test_pause();
    test_coincide();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
